fft_frame_loader: RTL

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

---
 rtl/fft_frame_loader_if.sv | 24 ++
 rtl/fft_frame_loader.sv | 92 +++++++++
 2 files changed

// File: rtl/fft_frame_loader_if.sv
// Handshake bundle between the sample source, the frame loader and the FFT consumer.
// The slave modport is the loader's view; master is the environment's view.
interface fft_frame_loader_if #(
  parameter int DW = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_last;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [8*DW-1:0]      frame_data;
  logic                 frame_err;

  modport slave (
    input  in_valid, in_data, in_last, frame_ready,
    output in_ready, frame_valid, frame_data, frame_err
  );

  modport master (
    output in_valid, in_data, in_last, frame_ready,
    input  in_ready, frame_valid, frame_data, frame_err
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong loader that gathers 8 real samples into a frame for an 8-point FFT,
// optionally scattering them into bit-reversed slot order as they arrive.
module fft_frame_loader #(
  parameter int DW     = 9,
  parameter int BITREV = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_frame_loader_if.slave bus
);

  typedef logic signed [DW-1:0] samp_t;

  samp_t           bank_q [2][8];
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [2:0]      wr_idx_q, wr_idx_d;
  logic            err_q, err_d;

  logic            accept, abort, wr_en, frame_done, consume;
  logic [2:0]      slot;
  logic [8*DW-1:0] frame_data_w;

  function automatic logic [2:0] bitrev3(input logic [2:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

  // Handshake outputs come straight from registered flags, no input feedthrough.
  assign bus.in_ready    = ~full_q[wr_bank_q];
  assign bus.frame_valid = full_q[rd_bank_q];
  assign bus.frame_err   = err_q;

  assign accept     = bus.in_valid & ~full_q[wr_bank_q];
  assign abort      = accept & bus.in_last & (wr_idx_q != 3'd7);
  assign wr_en      = accept & ~abort;
  assign frame_done = wr_en & (wr_idx_q == 3'd7);
  assign consume    = full_q[rd_bank_q] & bus.frame_ready;
  assign slot       = (BITREV != 0) ? bitrev3(wr_idx_q) : wr_idx_q;

  // Fill and consume always target different banks, so both may land together.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    err_d     = abort;
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (abort)      wr_idx_d = 3'd0;
    else if (wr_en) wr_idx_d = wr_idx_q + 3'd1;
  end

  always_comb begin
    frame_data_w = '0;
    for (int j = 0; j < 8; j++) begin
      frame_data_w[j*DW +: DW] = bank_q[rd_bank_q][j];
    end
  end
  assign bus.frame_data = frame_data_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= 3'd0;
      err_q     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < 8; j++) begin
          bank_q[b][j] <= '0;
        end
      end
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      err_q     <= err_d;
      if (wr_en) begin
        bank_q[wr_bank_q][slot] <= bus.in_data;
      end
    end
  end

endmodule
